// File: rtl/painel_pkg.sv
// Shared definitions for the panel control stage: shift-register mode
// codes, controller state encoding and the four stored messages.
package painel_pkg;

  // Mode lines {ch1,ch0} driven into the universal shift register
  localparam logic [1:0] MODO_HOLD  = 2'b00;
  localparam logic [1:0] MODO_DIR   = 2'b01;
  localparam logic [1:0] MODO_ESQ   = 2'b10;
  localparam logic [1:0] MODO_CARGA = 2'b11;

  localparam int unsigned MSG_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    PAUSED = 2'd3
  } estado_t;

  // Stored message lookup
  function automatic logic [MSG_W-1:0] msg(input logic [1:0] idx);
    logic [MSG_W-1:0] m;
    case (idx)
      2'd0:    m = 16'hF0F0;
      2'd1:    m = 16'h8001;
      2'd2:    m = 16'hAAAA;
      default: m = 16'h00FF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Loadable down-counter producing the rotation tick.
//   clk, rst_n : clock, async active-low reset
//   carga      : load periodo (highest priority)
//   congela    : hold the current count
//   periodo    : reload value, also used on every terminal count
//   tick_c     : combinational, high in the cycle whose closing edge is a tick
module divisor_tick #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carga,
  input  logic         congela,
  input  logic [W-1:0] periodo,
  output logic         tick_c
);

  logic [W-1:0] cnt;

  // A count of 1 always completes, even when frozen, so a rotation that is
  // already due is never swallowed; zero (idle) never decrements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (carga) begin
      cnt <= periodo;
    end else if (cnt == W'(1)) begin
      cnt <= periodo;
    end else if (!congela && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick_c = !carga && (cnt == W'(1));

endmodule

// File: rtl/controle_painel.sv
// Control stage for the 16-bit panel shift register: one parallel load of a
// selected message, then periodic rotation with pause/restart and a wrap pulse.
//   clk, rst_n        : clock, async active-low reset
//   start             : (re)load request, latches sel_msg and dir
//   pause             : freeze rotation while scrolling
//   sel_msg, dir      : message index and rotation direction (1 = right)
//   speed             : period multiplier, TICK_DIV << speed
//   ch1, ch0          : register mode lines
//   cadeiaDeBits      : parallel-load data
//   busy              : high once a message has been loaded
//   wrap              : one-cycle pulse on every 16th rotation
module controle_painel
  import painel_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic [1:0]       sel_msg,
  input  logic             dir,
  input  logic [1:0]       speed,
  output logic             ch0,
  output logic             ch1,
  output logic [MSG_W-1:0] cadeiaDeBits,
  output logic             busy,
  output logic             wrap
);

  localparam int unsigned CNT_W = $clog2(8 * TICK_DIV + 1);

  estado_t          estado;
  logic [1:0]       modo;
  logic             dir_lat;
  logic [3:0]       n_desloc;
  logic [CNT_W-1:0] periodo;
  logic             carga_c;
  logic             congela_c;
  logic             tick_c;

  // Period follows speed live; it is only consumed at load and reload edges
  assign periodo = CNT_W'(TICK_DIV) << speed;

  // start is ignored during LOAD so a held start alternates LOAD/SCROLL
  assign carga_c   = start && (estado != LOAD);
  assign congela_c = (estado == IDLE) || (pause && (estado != LOAD));

  divisor_tick #(
    .W (CNT_W)
  ) u_divisor (
    .clk     (clk),
    .rst_n   (rst_n),
    .carga   (carga_c),
    .congela (congela_c),
    .periodo (periodo),
    .tick_c  (tick_c)
  );

  // State and registered outputs; outputs are computed for the next state.
  // cadeiaDeBits itself carries the latched message selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= IDLE;
      modo         <= MODO_HOLD;
      cadeiaDeBits <= '0;
      busy         <= 1'b0;
      wrap         <= 1'b0;
      dir_lat      <= 1'b0;
      n_desloc     <= '0;
    end else begin
      modo <= MODO_HOLD;
      wrap <= 1'b0;
      case (estado)
        IDLE: begin
          if (start) begin
            estado       <= LOAD;
            modo         <= MODO_CARGA;
            cadeiaDeBits <= msg(sel_msg);
            dir_lat      <= dir;
            busy         <= 1'b1;
            n_desloc     <= '0;
          end
        end
        LOAD: begin
          estado <= SCROLL;
        end
        SCROLL, PAUSED: begin
          if (start) begin
            estado       <= LOAD;
            modo         <= MODO_CARGA;
            cadeiaDeBits <= msg(sel_msg);
            dir_lat      <= dir;
            n_desloc     <= '0;
          end else begin
            if (tick_c) begin
              modo     <= dir_lat ? MODO_DIR : MODO_ESQ;
              n_desloc <= n_desloc + 4'd1;
              wrap     <= (n_desloc == 4'd15);
            end
            estado <= pause ? PAUSED : SCROLL;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign ch1 = modo[1];
  assign ch0 = modo[0];

endmodule
